// File: rtl/adder32_seq.sv
// adder32_seq
//   Runs a WORDS x 32-bit add or subtract through one shared external 32-bit
//   combinational adder. It feeds one word per cycle, least significant word
//   first, and chains the carry between words through an internal register.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             request, sampled only in IDLE
//   sub, cin          0: a+b+cin, 1: a-b-cin (cin is the borrow-in)
//   op_a, op_b        W-bit operands, latched when start is accepted
//   add_a/add_b/add_ci  drive to the external adder (0 outside RUN)
//   add_s/add_co      result from the external adder
//   busy              high in RUN
//   done              one-cycle pulse when the result is valid
//   result/cout/ovf   W-bit result, carry/borrow out, signed overflow
module adder32_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_ci,
  input  logic [31:0]           add_s,
  input  logic                  add_co,
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   result,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W     = 32 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [W-1:0]     a_reg, b_reg;
  logic             sub_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [31:0]      a_word, b_word;
  logic             last_word;

  // Word selection as a compare-per-word mux so WORDS=1 needs no special case.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_word = a_reg[i*32 +: 32];
        b_word = b_reg[i*32 +: 32];
      end
    end
  end

  assign last_word = (idx == IDX_W'(WORDS - 1));

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_a  = a_word;
      add_b  = sub_reg ? ~b_word : b_word;
      add_ci = carry;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_word) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            sub_reg <= sub;
            // Subtraction is a + ~b + 1 - borrow_in, so the initial carry is cin^sub.
            carry   <= cin ^ sub;
            idx     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) result[i*32 +: 32] <= add_s;
          end
          carry <= add_co;
          idx   <= idx + 1'b1;
          if (last_word) begin
            // Borrow-out is the inverted adder carry when subtracting.
            cout <= sub_reg ? ~add_co : add_co;
            ovf  <= (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder32_seq.sv
// Directed self-checking bench for adder32_seq. Models the external 32-bit
// adder with a continuous assignment and runs a WORDS=4 and a WORDS=1 instance.
module tb_adder32_seq;

  logic         clk = 1'b0;
  logic         rst, start, sub, cin;
  logic [127:0] op_a, op_b, result;
  logic [31:0]  add_a, add_b, add_s;
  logic         add_ci, add_co, busy, done, cout, ovf;

  logic         rst1, start1, sub1, cin1;
  logic [31:0]  op_a1, op_b1, result1;
  logic [31:0]  add_a1, add_b1, add_s1;
  logic         add_ci1, add_co1, busy1, done1, cout1, ovf1;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int dones;
  logic busy_at0, done_after;
  logic ci_log [16];

  always #5 clk = ~clk;

  assign {add_co, add_s}   = {1'b0, add_a}  + {1'b0, add_b}  + 33'(add_ci);
  assign {add_co1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + 33'(add_ci1);

  adder32_seq #(.WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
    .op_a(op_a), .op_b(op_b),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  adder32_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .sub(sub1), .cin(cin1),
    .op_a(op_a1), .op_b(op_b1),
    .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1),
    .add_s(add_s1), .add_co(add_co1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one WORDS=4 operation; records busy after the start edge, the
  // number of edges until done, add_ci per RUN cycle, and done one edge later.
  task automatic run4(input logic [127:0] a, input logic [127:0] b, input logic s, input logic c);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_at0 = busy;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (busy) ci_log[k-1] = add_ci;
      @(posedge clk); #1;
      if (done) lat = k;
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    rst1 = 1'b1; start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; op_a1 = '0; op_b1 = '0;
    for (int i = 0; i < 16; i++) ci_log[i] = 1'b0;
    #12;
    chk("reset_busy",   busy,   0);
    chk("reset_done",   done,   0);
    chk("reset_result", result, 0);
    chk("reset_cout",   cout,   0);
    chk("reset_ovf",    ovf,    0);
    chk("reset_add_a",  add_a,  0);
    chk("reset_add_b",  add_b,  0);
    chk("reset_add_ci", add_ci, 0);
    chk("reset1_busy",  busy1,  0);
    chk("reset1_result", result1, 0);
    @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;

    // 520 + 10 + 1
    run4(128'd520, 128'd10, 1'b0, 1'b1);
    chk("t1_busy_at_start", busy_at0, 1);
    chk("t1_latency", lat, 4);
    chk("t1_done_one_cycle", done_after, 0);
    chk("t1_result", result, 128'd531);
    chk("t1_cout", cout, 0);
    chk("t1_ovf", ovf, 0);

    // all-ones + 1: carry ripples through every word
    run4({128{1'b1}}, 128'd1, 1'b0, 1'b0);
    chk("t2_latency", lat, 4);
    chk("t2_result", result, 0);
    chk("t2_cout", cout, 1);
    chk("t2_ovf", ovf, 0);
    chk("t2_ci_w0", ci_log[0], 0);
    chk("t2_ci_w1", ci_log[1], 1);
    chk("t2_ci_w2", ci_log[2], 1);
    chk("t2_ci_w3", ci_log[3], 1);

    // 100 - 200
    run4(128'd100, 128'd200, 1'b1, 1'b0);
    chk("t3_result", result, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF9C);
    chk("t3_borrow", cout, 1);
    chk("t3_ovf", ovf, 0);

    // largest positive + 1 overflows to the most negative value
    run4({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0);
    chk("t4_result", result, {1'b1, 127'd0});
    chk("t4_ovf", ovf, 1);
    chk("t4_cout", cout, 0);

    // start pulsed during RUN must be ignored
    @(negedge clk);
    op_a = 128'd63; op_b = 128'd211; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    op_a = 128'd37; op_b = 128'd48; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("t5_done_count", dones, 1);
    chk("t5_result", result, 128'd274);
    run4(128'd37, 128'd48, 1'b0, 1'b0);
    chk("t5_followup_latency", lat, 4);
    chk("t5_followup_result", result, 128'd85);

    // reset in the second RUN cycle
    @(negedge clk);
    op_a = 128'd5; op_b = 128'd6; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("t6_busy_before_rst", busy, 1);
    chk("t6_word0_before_rst", result, 128'd11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy",   busy,   0);
    chk("t6_rst_done",   done,   0);
    chk("t6_rst_result", result, 0);
    chk("t6_rst_cout",   cout,   0);
    chk("t6_rst_ovf",    ovf,    0);
    chk("t6_rst_add_a",  add_a,  0);
    chk("t6_rst_add_b",  add_b,  0);
    chk("t6_rst_add_ci", add_ci, 0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("t6_no_done", dones, 0);
    run4(128'd1000, 128'd24, 1'b0, 1'b0);
    chk("t6_recover_latency", lat, 4);
    chk("t6_recover_result", result, 128'd1024);

    // WORDS=1 instance: 127 + 127 + 1
    @(negedge clk);
    op_a1 = 32'd127; op_b1 = 32'd127; sub1 = 1'b0; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_done_early", done1, 0);
    @(posedge clk); #1;
    chk("w1_done", done1, 1);
    chk("w1_busy_off", busy1, 0);
    chk("w1_result", result1, 128'd255);
    chk("w1_cout", cout1, 0);
    chk("w1_ovf", ovf1, 0);
    @(posedge clk); #1;
    chk("w1_done_one_cycle", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder32_seq.md
# adder32_seq

Multi-word add/subtract sequencer that drives a single shared `adder32` (32-bit ripple adder with ports `s`, `co`, `a`, `b`, `ci`). It computes one `WORDS`×32-bit sum or difference by feeding the adder one 32-bit word per cycle, LSW first, and chaining carry through an internal register. It sits between the wide-arithmetic client and the adder instance. The adder itself stays purely combinational and external.

## Interface
- `WORDS`, 4, number of 32-bit words per operand (≥1); operand width W = 32·`WORDS`
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `sub`  in  1  0: a+b+cin; 1: a−b−cin (cin acts as borrow-in)
- `cin`  in  1  carry/borrow in
- `op_a`  in  W  operand A, latched on accepted start
- `op_b`  in  W  operand B, latched on accepted start
- `add_a`  out  32  to adder `a`
- `add_b`  out  32  to adder `b`
- `add_ci`  out  1  to adder `ci`
- `add_s`  in  32  from adder `s`
- `add_co`  in  1  from adder `co`
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse, result valid
- `result`  out  W  sum/difference, held until next accepted start
- `cout`  out  1  carry-out (add) or borrow-out (sub)
- `ovf`  out  1  two's-complement signed overflow of the W-bit operation

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE, `start`=1 at an edge:
  - latch `op_a`, `op_b`, `sub`, `cin`
  - idx←0, carry register←`cin`^`sub`
  - clear `result`, `cout`, `ovf`
  - go to RUN
- RUN, adder drive (combinational from latched state):
  - `add_a` = A word[idx]
  - `add_b` = `sub` ? ~B word[idx] : B word[idx]
  - `add_ci` = carry register
- RUN, each edge:
  - result word[idx]←`add_s`
  - carry←`add_co`
  - idx←idx+1
  - on the edge where idx=WORDS−1, go to DONE
- On the final RUN edge, also register:
  - `cout` ← `sub` ? ~`add_co` : `add_co`
  - `ovf` ← (`add_a`[31]==`add_b`[31]) && (`add_s`[31]!=`add_a`[31])
  - Note: `add_b` here is the post-inversion word.
- DONE: `done`=1 for this single cycle, then IDLE unconditionally.
- `start` in RUN or DONE is ignored, not queued. Operand inputs may change freely after acceptance.
- Outside RUN, `add_a`, `add_b` and `add_ci` are driven to 0.
- Arithmetic is modulo 2^W. `result` words are written in place; upper words stay 0 until their cycle.
- Reset (any time, including mid-RUN) forces IDLE and clears idx, carry and all outputs. No `done` is produced for an aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0, `add_a`=0, `add_b`=0, `add_ci`=0.
- Start accepted at edge E0. `busy` is high from E0 to E(WORDS).
- `done` is high from E(WORDS) to E(WORDS+1). `result`, `cout` and `ovf` are valid from E(WORDS).
- Earliest next accepted start: edge E(WORDS+2) (must be in IDLE). Throughput is one operation per WORDS+2 cycles.
- The adder path `add_a`/`add_b`/`add_ci` → `add_s`/`add_co` is a single-cycle combinational path. No multicycle constraint is needed.
- `WORDS`=1: `busy` is high for one cycle and `done` rises one edge after start.

## Test plan
- WORDS=4, `op_a`=520, `op_b`=10, `cin`=1, `sub`=0:
  - `result`=531, `cout`=0, `ovf`=0
  - `done` is high exactly 4 edges after the start edge, for one cycle
- WORDS=4, `op_a`=2^128−1, `op_b`=1, `cin`=0:
  - `result`=0, `cout`=1, `ovf`=0
  - `add_ci`=1 observed in words 1–3
- WORDS=4, `sub`=1, `op_a`=100, `op_b`=200, `cin`=0:
  - `result`=2^128−100, `cout`(borrow)=1, `ovf`=0
- WORDS=4, `op_a`=2^127−1, `op_b`=1, `sub`=0:
  - `result`=2^127, `ovf`=1, `cout`=0
- Pulse `start` (`op_a`=37, `op_b`=48) during RUN of a 63+211 operation:
  - only 274 is produced and one `done` pulse occurs
  - a later IDLE start with 37+48 gives 85
- Assert `rst` in the 2nd RUN cycle:
  - all outputs are immediately 0 and no `done` occurs
  - a new start after release with WORDS=1, `op_a`=127, `op_b`=127, `cin`=1 (separate build) gives `result`=255 with `done` one edge after start
